// File: rtl/rtl_core_pkg.sv
// -----------------------------------------------------------------------------
// rtl_core_pkg
// Shared defaults, the run-state enum and a small counter-width helper for the
// dual-reset secure status/data block (rtl_core and rtl_core_init_timer).
//
// Optional build macro used by rtl_core: WARM_SCRUB_EN.
// -----------------------------------------------------------------------------
package rtl_core_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int INIT_CYCLES_DEF = 4;
  localparam int STROBE_LOG2_DEF = 3;

  // ST_RUN is encoded as 1, so the state flop doubles as the status flop.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rtl_core_init_timer.sv
// -----------------------------------------------------------------------------
// rtl_core_init_timer
// Counts INIT_CYCLES clock edges after the last restart and then raises status.
// Restart is synchronous and returns the timer to ST_INIT with a zero count.
//
// Ports:
//   clk      in   clock
//   restart  in   synchronous restart (driven by rst1 | rst2)
//   status   out  high once initialised (registered)
//   state    out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module rtl_core_init_timer
  import rtl_core_pkg::*;
#(
  parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       restart,
  output logic       status,
  output run_state_e state
);

  localparam int              CNT_W = cnt_width(INIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INIT_CYCLES - 1);

  run_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The edge on which the count sits at LAST is the INIT_CYCLES-th edge
  // since restart released; status rises on that edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign status = (state_q == ST_RUN);
  assign state  = state_q;

endmodule

// File: rtl/rtl_core.sv
// -----------------------------------------------------------------------------
// rtl_core
// Dual-reset secure status/data block. On cold-reset (rst1) release the
// security mode is latched once from secure_in; after an initialisation delay
// status asserts and a free-running counter drives data with a periodic
// one-cycle strobe. Warm reset (rst2) restarts operation but keeps the latched
// security mode.
//
// Build macro: WARM_SCRUB_EN -- when defined, rst2 clears data if the latched
// mode is secure; when undefined, rst2 always holds data.
//
// Ports:
//   clk         in   single clock
//   rst1        in   cold reset, synchronous active-high (priority)
//   rst2        in   warm reset, synchronous active-high
//   secure_in   in   requested security mode, captured once after rst1
//   secure_out  out  latched security mode
//   status      out  high when initialised and running
//   strobe      out  one-cycle pulse every 2**STROBE_LOG2 increments
//   data        out  running counter value
// All outputs are registered.
// -----------------------------------------------------------------------------
module rtl_core
  import rtl_core_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int STROBE_LOG2 = STROBE_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst1,
  input  logic              rst2,
  input  logic              secure_in,
  output logic              secure_out,
  output logic              status,
  output logic              strobe,
  output logic [DATA_W-1:0] data
);

  logic              secure_q;
  logic              cap_pending_q;
  logic              strobe_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_next;
  logic              strobe_next;
  logic              timer_status;
  run_state_e        run_state;
  logic              running;

  rtl_core_init_timer #(
    .INIT_CYCLES (INIT_CYCLES)
  ) u_init_timer (
    .clk     (clk),
    .restart (rst1 | rst2),
    .status  (timer_status),
    .state   (run_state)
  );

  assign running     = (run_state == ST_RUN);
  assign data_next   = data_q + DATA_W'(1);
  // Strobe marks every new value whose low bits are zero, wrap to 0 included.
  assign strobe_next = (data_next[STROBE_LOG2-1:0] == '0);

  always_ff @(posedge clk) begin
    if (rst1) begin
      secure_q      <= 1'b0;
      cap_pending_q <= 1'b1;
      strobe_q      <= 1'b0;
      data_q        <= '0;
    end else begin
      // One-shot capture on the first edge out of cold reset, even if the
      // warm reset is still held.
      if (cap_pending_q) begin
        secure_q      <= secure_in;
        cap_pending_q <= 1'b0;
      end
      if (rst2) begin
        strobe_q <= 1'b0;
`ifdef WARM_SCRUB_EN
        if (secure_q) begin
          data_q <= '0;
        end
`endif
      end else if (running) begin
        data_q   <= data_next;
        strobe_q <= strobe_next;
      end else begin
        strobe_q <= 1'b0;
      end
    end
  end

  assign secure_out = secure_q;
  assign status     = timer_status;
  assign strobe     = strobe_q;
  assign data       = data_q;

endmodule

// File: tb/tb_rtl_core.sv
// -----------------------------------------------------------------------------
// tb_rtl_core
// Directed bench for rtl_core: cold reset, security capture, warm reset pulses,
// overlapping resets, simultaneous resets and counter wrap (on a narrow
// instance with DATA_W=4 and INIT_CYCLES=1).
// -----------------------------------------------------------------------------
module tb_rtl_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst2, secure_in;
  logic        secure_out, status, strobe;
  logic [31:0] data;

  logic        s_rst1, s_rst2, s_secure_in;
  logic        s_secure_out, s_status, s_strobe;
  logic [3:0]  s_data;

  rtl_core u_dut (
    .clk        (clk),
    .rst1       (rst1),
    .rst2       (rst2),
    .secure_in  (secure_in),
    .secure_out (secure_out),
    .status     (status),
    .strobe     (strobe),
    .data       (data)
  );

  rtl_core #(
    .DATA_W      (4),
    .INIT_CYCLES (1),
    .STROBE_LOG2 (3)
  ) u_small (
    .clk        (clk),
    .rst1       (s_rst1),
    .rst2       (s_rst2),
    .secure_in  (s_secure_in),
    .secure_out (s_secure_out),
    .status     (s_status),
    .strobe     (s_strobe),
    .data       (s_data)
  );

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance n rising edges, then settle 1ns so outputs are sampled away from the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] warm_exp;
  logic [31:0] exp_v;

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; secure_in = 1'b0;
    s_rst1 = 1'b1; s_rst2 = 1'b0; s_secure_in = 1'b0;

    // ---- cold reset, secure_in=0 ----
    tick(5);
    check("rst_secure", {31'd0, secure_out}, 32'd0);
    check("rst_status", {31'd0, status}, 32'd0);
    check("rst_strobe", {31'd0, strobe}, 32'd0);
    check("rst_data", data, 32'd0);

    rst1 = 1'b0; rst2 = 1'b0;
    tick(1);
    check("cap0_secure", {31'd0, secure_out}, 32'd0);
    check("init_e1_status", {31'd0, status}, 32'd0);
    tick(2);
    check("init_e3_status", {31'd0, status}, 32'd0);
    tick(1);
    check("init_e4_status", {31'd0, status}, 32'd1);
    check("init_e4_data", data, 32'd0);

    for (int v = 1; v <= 20; v++) exp_q.push_back(v);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      tick(1);
      check("run_data", data, exp_v);
      check("run_strobe", {31'd0, strobe}, {31'd0, (exp_v == 8 || exp_v == 16)});
    end

    // ---- rst2 pulse, secure_out=0: data holds in either build ----
    rst2 = 1'b1;
    tick(1);
    check("w0_status", {31'd0, status}, 32'd0);
    check("w0_data", data, 32'd20);
    check("w0_strobe", {31'd0, strobe}, 32'd0);
    tick(1);
    check("w0_data2", data, 32'd20);
    check("w0_secure", {31'd0, secure_out}, 32'd0);
    rst2 = 1'b0;
    tick(3);
    check("w0_rel3_status", {31'd0, status}, 32'd0);
    check("w0_rel3_data", data, 32'd20);
    tick(1);
    check("w0_rel4_status", {31'd0, status}, 32'd1);
    tick(1);
    check("w0_resume", data, 32'd21);

    // ---- cold reset with secure_in=1, then toggled ----
    rst1 = 1'b1;
    tick(2);
    check("c1_rst_secure", {31'd0, secure_out}, 32'd0);
    check("c1_rst_data", data, 32'd0);
    secure_in = 1'b1; rst1 = 1'b0;
    tick(1);
    check("c1_cap", {31'd0, secure_out}, 32'd1);
    secure_in = 1'b0;
    tick(3);
    check("c1_status", {31'd0, status}, 32'd1);
    check("c1_secure_held", {31'd0, secure_out}, 32'd1);
    tick(5);
    check("c1_data5", data, 32'd5);

    // ---- rst2 pulse with secure_out=1 ----
`ifdef WARM_SCRUB_EN
    warm_exp = 32'd0;
`else
    warm_exp = 32'd5;
`endif
    rst2 = 1'b1;
    tick(2);
    check("w1_data", data, warm_exp);
    check("w1_status", {31'd0, status}, 32'd0);
    check("w1_secure", {31'd0, secure_out}, 32'd1);
    rst2 = 1'b0;
    tick(4);
    check("w1_status_back", {31'd0, status}, 32'd1);
    check("w1_data_held", data, warm_exp);
    tick(1);
    check("w1_resume", data, warm_exp + 32'd1);

    // ---- rst2 held across an rst1 pulse ----
    rst2 = 1'b1;
    tick(1);
    rst1 = 1'b1;
    tick(2);
    check("ov_rst_secure", {31'd0, secure_out}, 32'd0);
    check("ov_rst_data", data, 32'd0);
    secure_in = 1'b1; rst1 = 1'b0;
    tick(1);
    check("ov_cap", {31'd0, secure_out}, 32'd1);
    check("ov_status_a", {31'd0, status}, 32'd0);
    secure_in = 1'b0;
    tick(2);
    check("ov_status_b", {31'd0, status}, 32'd0);
    rst2 = 1'b0;
    tick(3);
    check("ov_rel3_status", {31'd0, status}, 32'd0);
    tick(1);
    check("ov_rel4_status", {31'd0, status}, 32'd1);
    check("ov_rel4_data", data, 32'd0);
    tick(1);
    check("ov_data1", data, 32'd1);
    check("ov_secure_kept", {31'd0, secure_out}, 32'd1);

    // ---- simultaneous rst1 + rst2 mid-run ----
    tick(3);
    check("sim_pre_data", data, 32'd4);
    rst1 = 1'b1; rst2 = 1'b1;
    tick(1);
    check("sim_secure", {31'd0, secure_out}, 32'd0);
    check("sim_status", {31'd0, status}, 32'd0);
    check("sim_strobe", {31'd0, strobe}, 32'd0);
    check("sim_data", data, 32'd0);
    rst1 = 1'b0; rst2 = 1'b0;
    tick(1);
    check("sim_cap", {31'd0, secure_out}, 32'd0);
    tick(3);
    check("sim_status_back", {31'd0, status}, 32'd1);

    // ---- narrow instance: INIT_CYCLES=1 and counter wrap ----
    s_rst1 = 1'b0;
    tick(1);
    check("sm_status", {31'd0, s_status}, 32'd1);
    check("sm_data0", {28'd0, s_data}, 32'd0);
    tick(8);
    check("sm_data8", {28'd0, s_data}, 32'd8);
    check("sm_strobe8", {31'd0, s_strobe}, 32'd1);
    tick(7);
    check("sm_data15", {28'd0, s_data}, 32'd15);
    check("sm_strobe15", {31'd0, s_strobe}, 32'd0);
    tick(1);
    check("sm_wrap_data", {28'd0, s_data}, 32'd0);
    check("sm_wrap_strobe", {31'd0, s_strobe}, 32'd1);
    tick(1);
    check("sm_after_wrap", {28'd0, s_data}, 32'd1);
    check("sm_after_strobe", {31'd0, s_strobe}, 32'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
